// File: rtl/bs_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings
// and the reserved-mode decode used at the pipe entry.
package bs_pipe_pkg;

   typedef enum logic [2:0] {
      MODE_SLL = 3'b000,
      MODE_SRL = 3'b001,
      MODE_SRA = 3'b010,
      MODE_ROL = 3'b011,
      MODE_ROR = 3'b100
   } bs_mode_e;

   // Encodings above ROR are reserved and pass the operand through untouched.
   function automatic logic mode_is_reserved(input logic [2:0] mode);
      return (mode > MODE_ROR);
   endfunction

endpackage

// File: rtl/bs_stage.sv
// One log stage of the barrel shifter: a conditional shift/rotate by DIST
// followed by the stage register and its load/hold control.
module bs_stage
   import bs_pipe_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SWIDTH  = 5,
   parameter int DIST    = 16,
   parameter int AMT_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              take,
   input  logic              prev_valid,
   input  logic [WIDTH-1:0]  prev_data,
   input  logic [SWIDTH-1:0] prev_amt,
   input  logic [2:0]        prev_mode,
   input  logic              prev_ill,
   input  logic              prev_sign,
   output logic              valid,
   output logic [WIDTH-1:0]  data,
   output logic [SWIDTH-1:0] amt,
   output logic [2:0]        mode,
   output logic              ill,
   output logic              sign
);

   logic              valid_reg;
   logic [WIDTH-1:0]  data_reg;
   logic [SWIDTH-1:0] amt_reg;
   logic [2:0]        mode_reg;
   logic              ill_reg;
   logic              sign_reg;
   logic [WIDTH-1:0]  shift_next;
   logic              load_en;

   always_comb begin
      shift_next = prev_data;
      if (prev_amt[AMT_BIT] && !prev_ill) begin
         case (prev_mode)
            MODE_SLL: shift_next = prev_data << DIST;
            MODE_SRL: shift_next = prev_data >> DIST;
            // Fill comes from the sign captured at accept, never from prev_data.
            MODE_SRA: shift_next = ({WIDTH{prev_sign}} << (WIDTH - DIST)) | (prev_data >> DIST);
            MODE_ROL: shift_next = (prev_data << DIST) | (prev_data >> (WIDTH - DIST));
            MODE_ROR: shift_next = (prev_data >> DIST) | (prev_data << (WIDTH - DIST));
            default:  shift_next = prev_data;
         endcase
      end
   end

   assign load_en = !valid_reg || take;

   // Payload only moves with a valid op, so an idle stage keeps its last contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
         amt_reg   <= '0;
         mode_reg  <= '0;
         ill_reg   <= 1'b0;
         sign_reg  <= 1'b0;
      end else if (load_en) begin
         valid_reg <= prev_valid;
         if (prev_valid) begin
            data_reg <= shift_next;
            amt_reg  <= prev_amt;
            mode_reg <= prev_mode;
            ill_reg  <= prev_ill;
            sign_reg <= prev_sign;
         end
      end
   end

   assign valid = valid_reg;
   assign data  = data_reg;
   assign amt   = amt_reg;
   assign mode  = mode_reg;
   assign ill   = ill_reg;
   assign sign  = sign_reg;

endmodule

// File: rtl/bs_pipe.sv
// Pipelined barrel shifter: SWIDTH registered log stages, largest distance
// first, with valid/ready flow control on both sides.
module bs_pipe
   import bs_pipe_pkg::*;
#(
   parameter  int WIDTH  = 32,
   localparam int SWIDTH = $clog2(WIDTH)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [2:0]        MODE,
   input  logic [SWIDTH-1:0] BS_AMT,
   input  logic [WIDTH-1:0]  D_IN,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [WIDTH-1:0]  D_OUT,
   output logic              OUT_ILL
);

   // Index 0 is the input port side, index k is the output of stage k.
   logic [SWIDTH:0]   valid_c;
   logic [SWIDTH:0]   ill_c;
   logic [SWIDTH:0]   sign_c;
   logic [WIDTH-1:0]  data_c [0:SWIDTH];
   logic [SWIDTH-1:0] amt_c  [0:SWIDTH];
   logic [2:0]        mode_c [0:SWIDTH];
   logic [SWIDTH-1:0] take_c;
   logic              unused_tail;

   assign valid_c[0] = IN_VALID;
   assign data_c[0]  = D_IN;
   assign amt_c[0]   = BS_AMT;
   assign mode_c[0]  = MODE;
   assign ill_c[0]   = mode_is_reserved(MODE);
   assign sign_c[0]  = D_IN[WIDTH-1];

   genvar gi;
   generate
      for (gi = 0; gi < SWIDTH; gi++) begin : g_stage
         localparam int AMT_BIT = SWIDTH - 1 - gi;

         // A stage may hand its op on when any later stage has a hole or the
         // consumer is taking; written flat so the ready path has no chain.
         if (gi == SWIDTH - 1) begin : g_last
            assign take_c[gi] = OUT_READY;
         end else begin : g_mid
            assign take_c[gi] = OUT_READY || !(&valid_c[SWIDTH:gi+2]);
         end

         bs_stage #(
            .WIDTH   (WIDTH),
            .SWIDTH  (SWIDTH),
            .DIST    (1 << AMT_BIT),
            .AMT_BIT (AMT_BIT)
         ) u_stage (
            .clk        (CLK),
            .rst        (RST),
            .take       (take_c[gi]),
            .prev_valid (valid_c[gi]),
            .prev_data  (data_c[gi]),
            .prev_amt   (amt_c[gi]),
            .prev_mode  (mode_c[gi]),
            .prev_ill   (ill_c[gi]),
            .prev_sign  (sign_c[gi]),
            .valid      (valid_c[gi+1]),
            .data       (data_c[gi+1]),
            .amt        (amt_c[gi+1]),
            .mode       (mode_c[gi+1]),
            .ill        (ill_c[gi+1]),
            .sign       (sign_c[gi+1])
         );
      end
   endgenerate

   assign IN_READY  = !RST && (OUT_READY || !(&valid_c[SWIDTH:1]));
   assign OUT_VALID = valid_c[SWIDTH];
   assign D_OUT     = data_c[SWIDTH];
   assign OUT_ILL   = ill_c[SWIDTH];

   assign unused_tail = ^{amt_c[SWIDTH], mode_c[SWIDTH], sign_c[SWIDTH]};

endmodule
